// File: rtl/hexdisp_pkg.sv
// Shared constants for the seven-segment hex driver feeder: FSM encoding,
// driver register addresses and the 6-digit saturation value.
package hexdisp_pkg;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_CONV    = 2'd1;
  localparam logic [1:0] S_WR_VAL  = 2'd2;
  localparam logic [1:0] S_WR_MODE = 2'd3;

  localparam logic ADDR_HEXVAL = 1'b0;
  localparam logic ADDR_MODE   = 1'b1;

  localparam int NDIGITS = 6;
  localparam int MAX_DEC = 999999;

  localparam logic [4*NDIGITS-1:0] BCD_SAT = 24'h999999;

  // Driver hexval register layout: digits in the low 24 bits, rest zero.
  function automatic logic [31:0] hexval_word(input logic [4*NDIGITS-1:0] bcd);
    return {8'h00, bcd};
  endfunction

endpackage

// File: rtl/bcd_hex_writer_if.sv
// Upstream value/mode inputs and the downstream driver register write port.
interface bcd_hex_writer_if #(
  parameter int BIN_W = 20
) ();

  logic             in_valid;
  logic             in_ready;
  logic [BIN_W-1:0] in_data;
  logic             mode_set;
  logic             mode_bit;
  logic             address;
  logic             write;
  logic [31:0]      writedata;
  logic             overflow;

  modport slave (
    input  in_valid, in_data, mode_set, mode_bit,
    output in_ready, address, write, writedata, overflow
  );

  modport master (
    output in_valid, in_data, mode_set, mode_bit,
    input  in_ready, address, write, writedata, overflow
  );

endinterface

// File: rtl/bcd_add3.sv
// Double-dabble digit correction: nibbles of 5 or more get 3 added before the shift.
module bcd_add3 (
  input  logic [3:0] nib,
  output logic [3:0] res
);

  assign res = (nib >= 4'd5) ? nib + 4'd3 : nib;

endmodule

// File: rtl/bcd_hex_writer.sv
// Converts a binary value to 6 BCD digits (one bit per cycle) and writes it to the
// hex driver; mode requests are queued and written to the driver's mode register.
module bcd_hex_writer
  import hexdisp_pkg::*;
#(
  parameter int BIN_W   = 20,
  parameter int MAX_DEC = hexdisp_pkg::MAX_DEC
) (
  input  logic              clk,
  input  logic              reset_n,
  bcd_hex_writer_if.slave   bus
);

  localparam int CNT_W = $clog2(BIN_W + 1);
  localparam int BCD_W = 4 * NDIGITS;

  logic [1:0]       state_reg, state_next;
  logic [BIN_W-1:0] bin_reg;
  logic [BCD_W-1:0] bcd_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             ovf_reg;
  logic             mode_pend_reg;
  logic             mode_val_reg;

  logic             write_reg;
  logic             address_reg;
  logic [31:0]      writedata_reg;
  logic             overflow_reg;

  logic [BCD_W-1:0] corrected;
  logic [BCD_W-1:0] bcd_shift;
  logic [BIN_W-1:0] bin_shift;
  logic             mode_pend_eff;
  logic             mode_val_eff;
  logic             ready;
  logic             accept;
  logic             conv_done;
  logic             in_over;

  generate
    for (genvar gi = 0; gi < NDIGITS; gi++) begin : g_digit
      bcd_add3 u_add3 (
        .nib (bcd_reg[4*gi +: 4]),
        .res (corrected[4*gi +: 4])
      );
    end
  endgenerate

  assign bcd_shift = {corrected[BCD_W-2:0], bin_reg[BIN_W-1]};
  assign bin_shift = bin_reg << 1;

  // A mode pulse arriving this cycle already blocks data, so mode always wins.
  assign mode_pend_eff = mode_pend_reg | bus.mode_set;
  assign mode_val_eff  = bus.mode_set ? bus.mode_bit : mode_val_reg;
  assign ready         = (state_reg == S_IDLE) & ~mode_pend_eff;
  assign accept        = bus.in_valid & ready;
  assign conv_done     = (state_reg == S_CONV) && (cnt_reg == CNT_W'(BIN_W - 1));
  assign in_over       = {{(32-BIN_W){1'b0}}, bus.in_data} > 32'(MAX_DEC);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE: begin
        if (mode_pend_eff)   state_next = S_WR_MODE;
        else if (accept)     state_next = S_CONV;
      end
      S_CONV:    if (conv_done) state_next = S_WR_VAL;
      S_WR_VAL:  state_next = mode_pend_eff ? S_WR_MODE : S_IDLE;
      S_WR_MODE: state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= S_IDLE;
      bin_reg       <= '0;
      bcd_reg       <= '0;
      cnt_reg       <= '0;
      ovf_reg       <= 1'b0;
      mode_pend_reg <= 1'b0;
      mode_val_reg  <= 1'b0;
      write_reg     <= 1'b0;
      address_reg   <= 1'b0;
      writedata_reg <= '0;
      overflow_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;

      if (accept) begin
        bin_reg <= bus.in_data;
        bcd_reg <= '0;
        cnt_reg <= '0;
        ovf_reg <= in_over;
      end else if (state_reg == S_CONV) begin
        bin_reg <= bin_shift;
        bcd_reg <= bcd_shift;
        cnt_reg <= cnt_reg + CNT_W'(1);
        // A carry out of the top digit can only mean the value exceeds 6 digits.
        ovf_reg <= ovf_reg | corrected[BCD_W-1];
      end

      // The mode write consumes the request, including a pulse arriving on entry.
      if (state_next == S_WR_MODE) mode_pend_reg <= 1'b0;
      else if (bus.mode_set)       mode_pend_reg <= 1'b1;
      if (bus.mode_set) mode_val_reg <= bus.mode_bit;

      write_reg    <= (state_next == S_WR_VAL) || (state_next == S_WR_MODE);
      overflow_reg <= (state_next == S_WR_VAL) & ovf_reg;
      if (state_next == S_WR_VAL) begin
        address_reg   <= ADDR_HEXVAL;
        writedata_reg <= hexval_word(ovf_reg ? BCD_SAT : bcd_shift);
      end else if (state_next == S_WR_MODE) begin
        address_reg   <= ADDR_MODE;
        writedata_reg <= {31'h0, mode_val_eff};
      end
    end
  end

  assign bus.in_ready  = ready;
  assign bus.write     = write_reg;
  assign bus.address   = address_reg;
  assign bus.writedata = writedata_reg;
  assign bus.overflow  = overflow_reg;

endmodule

// File: tb/tb_bcd_hex_writer.sv
// Randomized bench for bcd_hex_writer: an ordered queue of expected driver writes
// (value, address, cycle) built from decimal arithmetic, checked by a bus monitor.
module tb_bcd_hex_writer;

  localparam int BIN_W = 20;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  typedef struct {
    logic        addr;
    logic [31:0] data;
    logic        ovf;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;

  bcd_hex_writer_if #(.BIN_W(BIN_W)) bus ();

  bcd_hex_writer #(.BIN_W(BIN_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Decimal digits of the value, saturating at 999999.
  function automatic logic [31:0] model_word(input int unsigned v);
    logic [31:0] w;
    w = '0;
    if (v > 999999) return 32'h00999999;
    for (int i = 0; i < 6; i++) begin
      w[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return w;
  endfunction

  // Each accepted value must appear 21 cycles after the accept cycle.
  task automatic push_data(input int acc);
    exp_t e;
    e.addr = 1'b0;
    e.data = model_word(32'(bus.in_data));
    e.ovf  = (32'(bus.in_data) > 999999);
    e.cyc  = acc + 21;
    exp_q.push_back(e);
  endtask

  task automatic push_mode(input logic b, input int c);
    exp_t e;
    e.addr = 1'b1;
    e.data = {31'h0, b};
    e.ovf  = 1'b0;
    e.cyc  = c;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (reset_n) begin
      if (bus.write) begin
        if (exp_q.size() == 0) begin
          check("spurious_write", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          check("wr_address", bus.address, mon_e.addr);
          check("wr_data", bus.writedata, mon_e.data);
          check("wr_overflow", bus.overflow, mon_e.ovf);
          check("wr_cycle", cyc, mon_e.cyc);
        end
      end else begin
        check("overflow_idle", bus.overflow, 0);
      end
    end
  end

  task automatic wait_accept(output int acc);
    acc = -1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        acc = cyc;
        push_data(acc);
        break;
      end
    end
    if (acc < 0) check("accept_timeout", 0, 1);
    else begin
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic send(input logic [BIN_W-1:0] d, output int acc);
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    wait_accept(acc);
  endtask

  task automatic pulse_mode(input logic b);
    repeat ($urandom_range(1, 4)) @(posedge clk);
    #1;
    bus.mode_set = 1'b1;
    bus.mode_bit = b;
    @(posedge clk); #1;
    bus.mode_set = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    check("drain", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic check_outputs_clear(input string tag);
    check({tag, "_write"}, bus.write, 0);
    check({tag, "_address"}, bus.address, 0);
    check({tag, "_writedata"}, bus.writedata, 0);
    check({tag, "_overflow"}, bus.overflow, 0);
    check({tag, "_ready"}, bus.in_ready, 1);
  endtask

  initial begin
    int a1, a2, c, nm;
    logic last, b;
    logic [BIN_W-1:0] d;

    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.mode_set = 1'b0;
    bus.mode_bit = 1'b0;

    repeat (3) @(negedge clk);
    check_outputs_clear("reset");
    @(posedge clk); #1 reset_n = 1'b1;
    @(negedge clk);
    check_outputs_clear("post_reset");

    // Reset during a conversion discards it.
    send(20'd765432, a1);
    repeat (5) @(posedge clk);
    #1 reset_n = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check_outputs_clear("mid_conv_reset");
    @(posedge clk); #1 reset_n = 1'b1;
    @(negedge clk);
    check_outputs_clear("mid_conv_release");
    repeat (30) @(negedge clk);

    send(20'd123456, a1);
    drain();

    send(20'd0, a1);
    send(20'd999999, a2);
    check("b2b_accept_gap", a2 - a1, 22);
    drain();

    send(20'd1000000, a1);
    drain();

    // Mode request in the same cycle as data takes priority.
    @(posedge clk); #1;
    bus.in_valid = 1'b1;
    bus.in_data  = 20'd42;
    bus.mode_set = 1'b1;
    bus.mode_bit = 1'b1;
    @(negedge clk);
    c = cyc;
    check("ready_blocked_by_mode", bus.in_ready, 0);
    push_mode(1'b1, c + 1);
    @(posedge clk); #1 bus.mode_set = 1'b0;
    wait_accept(a1);
    check("accept_after_mode", a1 - c, 2);
    drain();

    // Mode pulses during conversion: deferred behind the value, last bit wins.
    send(20'd314159, a1);
    @(posedge clk); #1;
    bus.mode_set = 1'b1;
    bus.mode_bit = 1'b1;
    @(posedge clk); #1 bus.mode_bit = 1'b0;
    @(posedge clk); #1 bus.mode_set = 1'b0;
    push_mode(1'b0, a1 + 22);
    drain();

    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 9))
        0:       d = 20'd0;
        1:       d = 20'd999999;
        2:       d = BIN_W'($urandom_range(1000000, 1048575));
        default: d = BIN_W'($urandom_range(0, 999999));
      endcase
      send(d, a1);
      nm = $urandom_range(0, 2);
      last = 1'b0;
      for (int k = 0; k < nm; k++) begin
        b = 1'($urandom_range(0, 1));
        pulse_mode(b);
        last = b;
      end
      if (nm > 0) push_mode(last, a1 + 22);
      if ($urandom_range(0, 1) == 1) drain();
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
